// File: rtl/da_sequencer.sv
// da_sequencer: preloaded-FIFO playback controller that owns the DA_block
// we/din/outflag pins. The host fills the FIFO while IDLE, then start plays every
// stored sample at a programmed interval, followed by a fixed-length outflag burst.
module da_sequencer #(
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 4,
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned FLAG_CYC = 5
) (
    input  logic             dack,
    input  logic             reset,
    input  logic             host_we,
    input  logic [DW-1:0]    host_din,
    input  logic [DIV_W-1:0] rate,
    input  logic             start,
    input  logic             abort,
    output logic             host_full,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic             da_we,
    output logic [DW-1:0]    da_din,
    output logic             da_outflag
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned FW    = (FLAG_CYC > 1) ? $clog2(FLAG_CYC) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t            state;
    logic [DW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DIV_W-1:0]  rate_q;
    logic [DIV_W-1:0]  div;
    logic [AW:0]       rem;
    logic [FW-1:0]     fcnt;
    logic              start_ok;
    logic              push_en;

    assign host_full = (count == FULL_CNT);
    assign busy      = (state != IDLE);

    // An accepted start takes the edge, so a simultaneous push is discarded
    always_comb begin
        start_ok = (state == IDLE) && !abort && start && (count != '0);
        push_en  = (state == IDLE) && !abort && host_we && !host_full && !start_ok;
    end

    // Sample storage; only written while IDLE, read while starting or running
    always_ff @(posedge dack) begin
        if (push_en) begin
            mem[wr_ptr] <= host_din;
        end
    end

    // Control FSM, FIFO pointers and all registered outputs
    always_ff @(posedge dack or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rate_q     <= '0;
            div        <= '0;
            rem        <= '0;
            fcnt       <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            da_we      <= 1'b0;
            da_din     <= '0;
            da_outflag <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            done       <= 1'b0;
            da_we      <= 1'b0;
            da_outflag <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        rate_q   <= rate;
                        div      <= rate;
                        rem      <= count - 1'b1;
                        da_din   <= mem[rd_ptr];
                        rd_ptr   <= rd_ptr + 1'b1;
                        count    <= count - 1'b1;
                        da_we    <= 1'b1;
                        overflow <= 1'b0;
                        state    <= RUN;
                    end else if (push_en) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        count  <= count + 1'b1;
                    end else if (host_we && host_full) begin
                        overflow <= 1'b1;
                    end
                end
                RUN: begin
                    if (div != '0) begin
                        div <= div - 1'b1;
                    end else if (rem != '0) begin
                        da_din <= mem[rd_ptr];
                        rd_ptr <= rd_ptr + 1'b1;
                        count  <= count - 1'b1;
                        rem    <= rem - 1'b1;
                        div    <= rate_q;
                    end else begin
                        da_we      <= 1'b0;
                        da_outflag <= 1'b1;
                        fcnt       <= FW'(FLAG_CYC - 1);
                        state      <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fcnt == '0) begin
                        da_outflag <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        fcnt <= fcnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_da_sequencer.sv
// Bench for da_sequencer: a queue model of the FIFO produces the expected sample
// stream (each sample repeated rate+1 times); a negedge monitor consumes it.
module tb_da_sequencer;

    localparam int DW       = 8;
    localparam int AW       = 4;
    localparam int DIV_W    = 8;
    localparam int FLAG_CYC = 5;
    localparam int DEPTH    = 16;

    logic             dack     = 1'b0;
    logic             reset    = 1'b0;
    logic             host_we  = 1'b0;
    logic [DW-1:0]    host_din = '0;
    logic [DIV_W-1:0] rate     = '0;
    logic             start    = 1'b0;
    logic             abort    = 1'b0;
    logic             host_full;
    logic [AW:0]      count;
    logic             overflow;
    logic             busy;
    logic             done;
    logic             da_we;
    logic [DW-1:0]    da_din;
    logic             da_outflag;

    da_sequencer #(.DW(DW), .AW(AW), .DIV_W(DIV_W), .FLAG_CYC(FLAG_CYC)) dut (
        .dack(dack), .reset(reset), .host_we(host_we), .host_din(host_din),
        .rate(rate), .start(start), .abort(abort), .host_full(host_full),
        .count(count), .overflow(overflow), .busy(busy), .done(done),
        .da_we(da_we), .da_din(da_din), .da_outflag(da_outflag)
    );

    always #5 dack = ~dack;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_q[$];
    int exp_we_len = 0;
    int we_run     = 0;
    int flag_run   = 0;
    int done_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample stream, we burst length, outflag burst length, done pulses
    always @(negedge dack) begin
        if (!reset) begin
            we_run   = 0;
            flag_run = 0;
        end else begin
            if (da_we) begin
                we_run++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_we: da_we high with din %0h, nothing expected", da_din);
                end else begin
                    check("da_din", 32'(da_din), 32'(exp_q.pop_front()));
                end
            end else if (we_run != 0) begin
                check("we_len", we_run, exp_we_len);
                we_run = 0;
            end
            if (da_outflag) begin
                flag_run++;
            end else if (flag_run != 0) begin
                check("flag_len", flag_run, FLAG_CYC);
                check("done_at_flag_end", 32'(done), 32'(1));
                flag_run = 0;
            end
            if (done) done_seen++;
        end
    end

    task automatic push(input logic [DW-1:0] v);
        @(posedge dack); #1;
        host_we  = 1'b1;
        host_din = v;
        @(posedge dack); #1;
        host_we = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(v);
    endtask

    task automatic do_start(input int r);
        rate = DIV_W'(r);
        exp_we_len = model_q.size() * (r + 1);
        foreach (model_q[i]) repeat (r + 1) exp_q.push_back(model_q[i]);
        model_q.delete();
        @(posedge dack); #1;
        start = 1'b1;
        @(posedge dack); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'(1));
        check("first_sample_we", 32'(da_we), 32'(1));
        check("overflow_cleared", 32'(overflow), 32'(0));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(posedge dack); #1;
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", n);
        end
    endtask

    task automatic finish_play(input int d0, input string tag);
        wait_idle();
        @(posedge dack); #1;
        check({tag, "_done_pulses"}, done_seen - d0, 1);
        check({tag, "_exp_left"}, exp_q.size(), 0);
        check({tag, "_count"}, 32'(count), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done_low"}, 32'(done), 32'(0));
    endtask

    initial begin
        int d0;
        int n;
        int r;

        // 1: reset state
        #12;
        check("rst_we", 32'(da_we), 32'(0));
        check("rst_din", 32'(da_din), 32'(0));
        check("rst_flag", 32'(da_outflag), 32'(0));
        reset = 1'b1;
        @(posedge dack); #1;
        check("rst_count", 32'(count), 32'(0));
        check("rst_full", 32'(host_full), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        check("rst_done", 32'(done), 32'(0));

        // 2: eight samples at full rate
        for (int i = 1; i <= 8; i++) push(DW'(i));
        check("t2_count", 32'(count), 32'(8));
        d0 = done_seen;
        do_start(0);
        finish_play(d0, "t2");

        // 3: slow rate, rate change mid-run ignored
        push(8'hA5); push(8'h5A); push(8'hFF);
        d0 = done_seen;
        do_start(2);
        repeat (4) @(posedge dack);
        #1 rate = '0;
        finish_play(d0, "t3");

        // 4: overflow on the 17th push, start clears it and plays the first 16
        for (int i = 0; i < 17; i++) push(DW'($urandom));
        check("t4_count", 32'(count), 32'(16));
        check("t4_full", 32'(host_full), 32'(1));
        check("t4_ovf", 32'(overflow), 32'(1));
        d0 = done_seen;
        do_start(int'($urandom_range(0, 3)));
        check("t4_not_full", 32'(host_full), 32'(0));
        finish_play(d0, "t4");

        // random rounds
        for (int k = 0; k < 4; k++) begin
            n = int'($urandom_range(1, 16));
            r = int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) push(DW'($urandom));
            check("rnd_count", 32'(count), 32'(n));
            d0 = done_seen;
            do_start(r);
            finish_play(d0, "rnd");
        end

        // 5: abort while the third sample is on da_din
        for (int i = 0; i < 8; i++) push(DW'($urandom));
        d0 = done_seen;
        do_start(0);
        @(posedge dack); #1;
        @(posedge dack); #1;
        exp_we_len = 3;
        abort = 1'b1;
        @(posedge dack); #1;
        abort = 1'b0;
        exp_q.delete();
        check("t5_we", 32'(da_we), 32'(0));
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_count", 32'(count), 32'(0));
        check("t5_flag", 32'(da_outflag), 32'(0));
        repeat (10) @(posedge dack);
        #1 check("t5_no_done", done_seen - d0, 0);
        start = 1'b1;
        @(posedge dack); #1;
        start = 1'b0;
        repeat (3) @(posedge dack);
        #1;
        check("t5_empty_start_busy", 32'(busy), 32'(0));
        check("t5_empty_start_we", 32'(da_we), 32'(0));
        check("t5_empty_no_done", done_seen - d0, 0);

        // 6: asynchronous reset during FLUSH
        push(DW'($urandom)); push(DW'($urandom));
        do_start(0);
        n = 0;
        while (!da_outflag && n < 100) begin
            @(posedge dack); #1;
            n++;
        end
        check("t6_reached_flush", 32'(da_outflag), 32'(1));
        #2 reset = 1'b0;
        #1;
        check("t6_flag", 32'(da_outflag), 32'(0));
        check("t6_busy", 32'(busy), 32'(0));
        check("t6_din", 32'(da_din), 32'(0));
        check("t6_count", 32'(count), 32'(0));
        exp_q.delete();
        model_q.delete();
        @(posedge dack); #1;
        reset = 1'b1;
        @(posedge dack); #1;
        check("t6_after_busy", 32'(busy), 32'(0));
        check("t6_after_done", 32'(done), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
